// File: rtl/fmap_fb_writer_if.sv
// rtl/fmap_fb_writer_if.sv - pixel-in / framebuffer-write bundle for fmap_fb_writer
// master drives pixels and reads writes; slave is the writer block.
interface fmap_fb_writer_if #(
   parameter int RW     = 10,
   parameter int ADDR_W = 19
);
   logic              frame_start;
   logic              pixel_valid;
   logic [7:0]        gray_pixel;
   logic [RW-1:0]     pixel_row;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [7:0]        bram_wdata;
   logic              col_done;
   logic              frame_done;
   logic              seq_err;

   modport master (
      output frame_start, pixel_valid, gray_pixel, pixel_row,
      input  bram_we, bram_addr, bram_wdata, col_done, frame_done, seq_err
   );

   modport slave (
      input  frame_start, pixel_valid, gray_pixel, pixel_row,
      output bram_we, bram_addr, bram_wdata, col_done, frame_done, seq_err
   );
endinterface

// File: rtl/fmap_fb_writer.sv
// rtl/fmap_fb_writer.sv - writes a column-ordered feature map into a linear framebuffer
// Optional FMAP_FB_BINARIZE_EN: threshold pixels at 8'h80 to 8'h00/8'hFF.
module fmap_fb_writer #(
   parameter int PIX_W  = 24,
   parameter int PIX_H  = 24,
   parameter int X_SIZE = 640,
   parameter int Y_SIZE = 480,
   parameter int X_OFF  = 0,
   parameter int Y_OFF  = 0
) (
   input logic             clk,
   input logic             rst,
   fmap_fb_writer_if.slave fb
);
   localparam int ADDR_W = $clog2(X_SIZE * Y_SIZE);
   localparam int RW     = $clog2(X_SIZE);
   localparam int CW     = (PIX_W > 1) ? $clog2(PIX_W) : 1;

   typedef enum logic {IDLE, FILL} state_t;

   state_t            state_q, state_d, state_base;
   logic [RW-1:0]     row_q, row_d, row_base;
   logic [CW-1:0]     col_q, col_d, col_base;
   logic              err_q, err_d, err_base;
   logic              we_q, we_d;
   logic              cd_q, cd_d;
   logic              fd_q, fd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [7:0]        pix_data;
   logic              row_ok, row_last, col_last;

`ifdef FMAP_FB_BINARIZE_EN
   assign pix_data = fb.gray_pixel[7] ? 8'hFF : 8'h00;
`else
   assign pix_data = fb.gray_pixel;
`endif

   assign row_ok   = 32'(fb.pixel_row) < PIX_H;
   assign row_last = 32'(fb.pixel_row) == PIX_H - 1;
   assign col_last = 32'(col_base) == PIX_W - 1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         cd_q    <= 1'b0;
         fd_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         err_q   <= err_d;
         we_q    <= we_d;
         cd_q    <= cd_d;
         fd_q    <= fd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      // frame_start clears first so a coincident pixel lands in column 0
      state_base = fb.frame_start ? IDLE : state_q;
      row_base   = fb.frame_start ? '0 : row_q;
      col_base   = fb.frame_start ? '0 : col_q;
      err_base   = fb.frame_start ? 1'b0 : err_q;

      state_d = state_base;
      row_d   = row_base;
      col_d   = col_base;
      err_d   = err_base;
      we_d    = 1'b0;
      cd_d    = 1'b0;
      fd_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      case (state_base)
         IDLE, FILL: begin
            if (fb.pixel_valid) begin
               if (!row_ok) begin
                  err_d = 1'b1;
               end else begin
                  we_d    = 1'b1;
                  wdata_d = pix_data;
                  addr_d  = (ADDR_W'(Y_OFF) + ADDR_W'(fb.pixel_row)) * ADDR_W'(X_SIZE)
                          + ADDR_W'(X_OFF) + ADDR_W'(col_base);
                  if (fb.pixel_row != row_base)
                     err_d = 1'b1;
                  if (row_last) begin
                     row_d   = '0;
                     cd_d    = 1'b1;
                     state_d = IDLE;
                     if (col_last) begin
                        col_d = '0;
                        fd_d  = 1'b1;
                     end else begin
                        col_d = col_base + CW'(1);
                     end
                  end else begin
                     row_d   = fb.pixel_row + RW'(1);
                     state_d = FILL;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign fb.bram_we    = we_q;
   assign fb.bram_addr  = addr_q;
   assign fb.bram_wdata = wdata_q;
   assign fb.col_done   = cd_q;
   assign fb.frame_done = fd_q;
   assign fb.seq_err    = err_q;
endmodule

// File: tb/tb_fmap_fb_writer.sv
// tb/tb_fmap_fb_writer.sv - randomized and directed checks of fmap_fb_writer against a reference model
// Two instances: default origin and X_OFF=100/Y_OFF=50, driven with identical stimulus.
module tb_fmap_fb_writer;
   localparam int PIX_W = 24;
   localparam int PIX_H = 24;
   localparam int XS    = 640;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fs  = 1'b0;
   logic       pv  = 1'b0;
   logic [7:0] px  = 8'h00;
   logic [9:0] prow = '0;

   always #5 clk = ~clk;

   fmap_fb_writer_if #(.RW(10), .ADDR_W(19)) bus0 ();
   fmap_fb_writer_if #(.RW(10), .ADDR_W(19)) bus1 ();

   assign bus0.frame_start = fs;
   assign bus0.pixel_valid = pv;
   assign bus0.gray_pixel  = px;
   assign bus0.pixel_row   = prow;
   assign bus1.frame_start = fs;
   assign bus1.pixel_valid = pv;
   assign bus1.gray_pixel  = px;
   assign bus1.pixel_row   = prow;

   fmap_fb_writer dut0 (.clk(clk), .rst(rst), .fb(bus0));
   fmap_fb_writer #(.X_OFF(100), .Y_OFF(50)) dut1 (.clk(clk), .rst(rst), .fb(bus1));

   int n_cmp = 0;
   int n_mis = 0;

   // reference state: next expected row, current column, sticky error
   int         m_row, m_col;
   bit         m_err;
   bit         e_we, e_cd, e_fd;
   int         e_a0, e_a1;
   logic [7:0] e_wd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model(input bit f, input bit v, input logic [7:0] p, input int row);
      e_we = 0; e_cd = 0; e_fd = 0;
      if (f) begin
         m_row = 0; m_col = 0; m_err = 0;
      end
      if (v) begin
         if (row >= PIX_H) begin
            m_err = 1;
         end else begin
            if (row != m_row) m_err = 1;
            e_we = 1;
            e_a0 = row * XS + m_col;
            e_a1 = (50 + row) * XS + 100 + m_col;
`ifdef FMAP_FB_BINARIZE_EN
            e_wd = (p >= 8'h80) ? 8'hFF : 8'h00;
`else
            e_wd = p;
`endif
            if (row == PIX_H - 1) begin
               m_row = 0;
               e_cd  = 1;
               if (m_col == PIX_W - 1) begin
                  e_fd  = 1;
                  m_col = 0;
               end else begin
                  m_col++;
               end
            end else begin
               m_row = row + 1;
            end
         end
      end
   endtask

   task automatic compare();
      check("we0",  32'(bus0.bram_we),    32'(e_we));
      check("we1",  32'(bus1.bram_we),    32'(e_we));
      check("cd0",  32'(bus0.col_done),   32'(e_cd));
      check("cd1",  32'(bus1.col_done),   32'(e_cd));
      check("fd0",  32'(bus0.frame_done), 32'(e_fd));
      check("fd1",  32'(bus1.frame_done), 32'(e_fd));
      check("err0", 32'(bus0.seq_err),    32'(m_err));
      check("err1", 32'(bus1.seq_err),    32'(m_err));
      if (e_we) begin
         check("addr0", 32'(bus0.bram_addr),  32'(e_a0));
         check("addr1", 32'(bus1.bram_addr),  32'(e_a1));
         check("wd0",   32'(bus0.bram_wdata), 32'(e_wd));
         check("wd1",   32'(bus1.bram_wdata), 32'(e_wd));
      end
   endtask

   task automatic step(input bit f, input bit v, input logic [7:0] p, input int row);
      fs   = f;
      pv   = v;
      px   = p;
      prow = row[9:0];
      model(f, v, p, row);
      @(posedge clk);
      #1;
      compare();
      fs = 1'b0;
      pv = 1'b0;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      pv   = 1'b1;
      fs   = 1'($urandom);
      px   = 8'($urandom);
      prow = 10'($urandom_range(0, PIX_H - 1));
      @(posedge clk);
      #1;
      rst = 1'b0;
      pv  = 1'b0;
      fs  = 1'b0;
      m_row = 0; m_col = 0; m_err = 0;
      check("rst_we",    32'(bus0.bram_we),    32'd0);
      check("rst_addr",  32'(bus0.bram_addr),  32'd0);
      check("rst_wd",    32'(bus0.bram_wdata), 32'd0);
      check("rst_cd",    32'(bus0.col_done),   32'd0);
      check("rst_fd",    32'(bus0.frame_done), 32'd0);
      check("rst_err",   32'(bus0.seq_err),    32'd0);
      check("rst_addr1", 32'(bus1.bram_addr),  32'd0);
   endtask

   task automatic send_column(input int gap);
      for (int r = 0; r < PIX_H; r++) begin
         step(0, 1, 8'($urandom), r);
         for (int g = 0; g < gap; g++) step(0, 0, 8'($urandom), r);
      end
   endtask

   initial begin
      int r;
      int row;
      m_row = 0; m_col = 0; m_err = 0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // single column, value = row
      for (int i = 0; i < PIX_H; i++) step(0, 1, 8'(i), i);

      // remaining columns of the frame, then wrap to column 0
      for (int c = 1; c < PIX_W; c++) send_column(0);
      step(0, 1, 8'h5A, 0);

      // column with idle gaps
      do_reset();
      send_column(3);

      // skipped row, then frame_start clears sticky error
      do_reset();
      step(0, 1, 8'h11, 0);
      step(0, 1, 8'h22, 1);
      step(0, 1, 8'h33, 3);
      step(0, 1, 8'h44, 4);
      step(1, 0, 8'h00, 0);

      // abandon column 5 after 10 rows
      do_reset();
      for (int c = 0; c < 5; c++) send_column(0);
      for (int i = 0; i < 10; i++) step(0, 1, 8'($urandom), i);
      step(1, 0, 8'h00, 0);
      step(0, 1, 8'h77, 0);

      // frame_start together with a pixel, mid-column
      for (int i = 1; i < 6; i++) step(0, 1, 8'($urandom), i);
      step(1, 1, 8'h66, 0);

      // out-of-range rows
      step(0, 1, 8'h99, PIX_H);
      step(0, 1, 8'h98, PIX_H + 3);

      // binarize threshold values
      step(1, 1, 8'h7F, 0);
      step(0, 1, 8'h80, 1);

      // reset mid-column
      for (int i = 2; i < 7; i++) step(0, 1, 8'($urandom), i);
      do_reset();
      step(0, 1, 8'hC3, 0);

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         r = $urandom_range(0, 99);
         row = ($urandom_range(0, 99) < 6) ? $urandom_range(0, PIX_H + 2) : m_row;
         if (r < 1)
            do_reset();
         else
            step($urandom_range(0, 99) < 2, r < 75, 8'($urandom), row);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
